// File: rtl/i4003_pkg.sv
// Shared types and helpers for the i4003 serial loader.
package i4003_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT_LO,
    ST_SHIFT_HI,
    ST_DONE
  } state_e;

  // One i4003 holds ten bits; cascades are multiples of this.
  localparam int I4003_BITS = 10;

  // The bit counter holds WIDTH-1 down to 0.
  function automatic int bitcnt_w(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/i4003_ctrl_if.sv
// Load handshake and readback bus between a register block and i4003_ctrl.
// Signal names are seen from the controller side (_i into it, _o out of it).
interface i4003_ctrl_if #(
  parameter int WIDTH = 10
);
  logic             LOAD_VALID_i;
  logic             LOAD_READY_o;
  logic [WIDTH-1:0] LOAD_DATA_i;
  logic             DONE_o;
  logic [WIDTH-1:0] RD_DATA_o;

  modport master (
    output LOAD_VALID_i, LOAD_DATA_i,
    input  LOAD_READY_o, DONE_o, RD_DATA_o
  );

  modport slave (
    input  LOAD_VALID_i, LOAD_DATA_i,
    output LOAD_READY_o, DONE_o, RD_DATA_o
  );
endinterface

// File: rtl/i4003_cp_gen.sv
// CP phase generator: counts DIV clocks per CP half-period, strobes the last
// cycle of each half-period and toggles the CP level at that point.
module i4003_cp_gen #(
  parameter int DIV = 4
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_start,
  input  logic i_clr,
  output logic o_phase_end,
  output logic o_cp
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [PW-1:0] r_cnt;
  logic          r_cp;

  assign o_phase_end = (r_cnt == PW'(DIV - 1));
  assign o_cp        = r_cp;

  // Phase counter and CP level; held at zero whenever not shifting so the
  // first half-period after a start is always a full low phase.
  always_ff @(posedge i_clk) begin
    if (i_rst || i_start || i_clr) begin
      r_cnt <= '0;
      r_cp  <= 1'b0;
    end else if (o_phase_end) begin
      r_cnt <= '0;
      r_cp  <= ~r_cp;
    end else begin
      r_cnt <= r_cnt + PW'(1);
    end
  end

endmodule

// File: rtl/i4003_ctrl.sv
// Serial loader/sequencer for an i4003 chain (WIDTH bits, MSB first).
// E is held low while shifting and raised once the word is in place.
// Build option: define I4003_CTRL_READBACK_EN to capture the bits pushed out
// of SERIAL_OUT and present the previous chain contents on RD_DATA_o.
module i4003_ctrl
  import i4003_pkg::*;
#(
  parameter int WIDTH = I4003_BITS,
  parameter int DIV   = 4
) (
  input  logic              CLK_i,
  input  logic              RST_i,
  i4003_ctrl_if.slave       bus,
  output logic              CP_o,
  output logic              DATA_o,
  output logic              E_o,
  input  logic              SERIAL_IN_i
);

  localparam int CNT_W = bitcnt_w(WIDTH);

  state_e           r_state;
  state_e           w_next;
  logic [WIDTH-1:0] r_shift;
  logic [CNT_W-1:0] r_bitcnt;
  logic             r_data;
  logic             r_armed;
  logic             w_accept;
  logic             w_run;
  logic             w_phase_end;
  logic             w_cp;
  logic             w_last_bit;

  assign w_accept   = (r_state == ST_IDLE) && bus.LOAD_VALID_i;
  assign w_run      = (r_state == ST_SHIFT_LO) || (r_state == ST_SHIFT_HI);
  assign w_last_bit = (r_bitcnt == '0);

  i4003_cp_gen #(.DIV(DIV)) u_cp_gen (
    .i_clk       (CLK_i),
    .i_rst       (RST_i),
    .i_start     (w_accept),
    .i_clr       (~w_run),
    .o_phase_end (w_phase_end),
    .o_cp        (w_cp)
  );

  // State register.
  always_ff @(posedge CLK_i) begin
    if (RST_i) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  // Next-state: low half, high half per bit, then a one-cycle DONE.
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:     if (w_accept)    w_next = ST_SHIFT_LO;
      ST_SHIFT_LO: if (w_phase_end) w_next = ST_SHIFT_HI;
      ST_SHIFT_HI: if (w_phase_end) w_next = w_last_bit ? ST_DONE : ST_SHIFT_LO;
      ST_DONE:                      w_next = ST_IDLE;
      default:                      w_next = ST_IDLE;
    endcase
  end

  // Data shifter: DATA_o only changes on entry to a low half, so it is stable
  // across the CP rising edge; r_armed keeps E high in IDLE after a load.
  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_data   <= 1'b0;
      r_armed  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_shift  <= bus.LOAD_DATA_i << 1;
        r_data   <= bus.LOAD_DATA_i[WIDTH-1];
        r_bitcnt <= CNT_W'(WIDTH - 1);
        r_armed  <= 1'b0;
      end else if ((r_state == ST_SHIFT_HI) && w_phase_end && !w_last_bit) begin
        r_shift  <= r_shift << 1;
        r_data   <= r_shift[WIDTH-1];
        r_bitcnt <= r_bitcnt - CNT_W'(1);
      end
      if (r_state == ST_DONE) r_armed <= 1'b1;
    end
  end

  assign CP_o             = w_cp;
  assign DATA_o           = r_data;
  assign E_o              = (r_state == ST_DONE) || ((r_state == ST_IDLE) && r_armed);
  assign bus.LOAD_READY_o = (r_state == ST_IDLE);
  assign bus.DONE_o       = (r_state == ST_DONE);

`ifdef I4003_CTRL_READBACK_EN
  logic [WIDTH-1:0] r_cap;
  logic [WIDTH-1:0] r_rd;

  // Capture SERIAL_OUT just before each CP rise (old MSB leaves first), and
  // publish the full old word as the shifter enters DONE.
  always_ff @(posedge CLK_i) begin
    if (RST_i) begin
      r_cap <= '0;
      r_rd  <= '0;
    end else begin
      if ((r_state == ST_SHIFT_LO) && w_phase_end)
        r_cap <= (r_cap << 1) | WIDTH'(SERIAL_IN_i);
      if ((r_state == ST_SHIFT_HI) && w_phase_end && w_last_bit)
        r_rd <= r_cap;
    end
  end

  assign bus.RD_DATA_o = r_rd;
`else
  logic w_unused_serial;
  assign w_unused_serial = SERIAL_IN_i;
  assign bus.RD_DATA_o   = '0;
`endif

endmodule
